// File: rtl/inst_mem_loader.sv
// Boot-time instruction RAM loader: byte-stream program load, then combinational fetch for the core.
// Optional `LOADER_CHECKSUM_EN: the ld_last byte is an 8-bit checksum over the data; on mismatch the loader enters HALT.
module inst_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [31:0]       inst_adr,
    output logic [31:0]       inst,
    output logic              core_rst,
    output logic              loaded,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic [31:0]         mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;
    logic [31:0]         packed_word;
    logic                commit;
    logic [1:0]          adr_unused;

    assign adr_unused = inst_adr[1:0];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        byte_idx_d   = byte_idx_q;
        buf_d        = buf_q;
        word_count_d = word_count_q;
        err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        mem_we       = 1'b0;
        mem_waddr    = ptr_q;
        mem_wdata    = 32'h0;
        commit       = 1'b0;
        packed_word  = buf_q | ({24'h0, ld_data} << {byte_idx_q, 3'b000});

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    // The ld_last byte is the checksum: flush only the data bytes before it.
                    if (ld_last) begin
                        commit    = (byte_idx_q != 2'd0);
                        mem_wdata = buf_q;
                        if (sum_q == ld_data) begin
                            state_d = S_RUN;
                        end else begin
                            state_d = S_HALT;
                            err_d   = 1'b1;
                        end
                    end else begin
                        sum_d     = sum_q + ld_data;
                        commit    = (byte_idx_q == 2'd3);
                        mem_wdata = packed_word;
                    end
`else
                    commit    = ld_last || (byte_idx_q == 2'd3);
                    mem_wdata = packed_word;
                    if (ld_last) begin
                        state_d = S_RUN;
                    end
`endif
                    // A word completing with the RAM already full is dropped and flagged.
                    if (commit) begin
                        if (word_count_q == FULL) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we       = 1'b1;
                            mem_waddr    = word_count_q[ADDR_W-1:0];
                            word_count_d = word_count_q + 1'b1;
                        end
                    end
                    if (commit || ld_last) begin
                        byte_idx_d = 2'd0;
                        buf_d      = 32'h0;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        buf_d      = packed_word;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            byte_idx_q   <= 2'd0;
            buf_q        <= 32'h0;
            word_count_q <= '0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'h0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            byte_idx_q   <= byte_idx_d;
            buf_q        <= buf_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Fetches outside the RAM window, or before RUN, return a nop.
    always_comb begin
        inst = 32'h0;
        if (state_q == S_RUN && inst_adr[31:ADDR_W+2] == '0) begin
            inst = mem_q[inst_adr[ADDR_W+1:2]];
        end
    end

    assign ld_ready   = (state_q == S_LOAD);
    assign core_rst   = (state_q != S_RUN);
    assign loaded     = (state_q == S_RUN);
    assign word_count = word_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: clear timing, packing, padding, address window, overflow, mid-load reset.
// Checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;

    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      ldData = 8'h0;
    logic            ldValid = 1'b0;
    logic            ldLast = 1'b0;
    logic            ldReady;
    logic [31:0]     instAdr = 32'h0;
    logic [31:0]     inst;
    logic            coreRst;
    logic            loaded;
    logic [ADDR_W:0] wordCount;
    logic            err;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          phase;
        logic [31:0] adr;
        logic [31:0] exp;
        string       name;
    } read_vec_t;

    read_vec_t vecs[$];

    inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_data    (ldData),
        .ld_valid   (ldValid),
        .ld_last    (ldLast),
        .ld_ready   (ldReady),
        .inst_adr   (instAdr),
        .inst       (inst),
        .core_rst   (coreRst),
        .loaded     (loaded),
        .word_count (wordCount),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents one byte (after optional idle cycles with a stray ld_last) and holds it until accepted.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            ldValid = 1'b0;
            ldLast  = 1'b1;
            ldData  = 8'hEE;
            @(posedge clk); #1;
        end
        ldData  = d;
        ldValid = 1'b1;
        ldLast  = last;
        t = 0;
        while (ldReady !== 1'b1 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ready_timeout: got ld_ready=%b expected 1", ldReady);
        end
        @(posedge clk); #1;
        ldValid = 1'b0;
        ldLast  = 1'b0;
    endtask

    task automatic doReset(input string tag, input bit checkState, output int cycles, output int bad);
        rst     = 1'b0;
        ldValid = 1'b0;
        ldLast  = 1'b0;
        instAdr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        if (checkState) begin
            checkOutput({tag, "_rst_ld_ready"}, {31'h0, ldReady}, 32'h0);
            checkOutput({tag, "_rst_core_rst"}, {31'h0, coreRst}, 32'h1);
            checkOutput({tag, "_rst_loaded"}, {31'h0, loaded}, 32'h0);
            checkOutput({tag, "_rst_inst"}, inst, 32'h0);
            checkOutput({tag, "_rst_word_count"}, 32'(wordCount), 32'h0);
            checkOutput({tag, "_rst_err"}, {31'h0, err}, 32'h0);
        end
        rst    = 1'b1;
        cycles = 0;
        bad    = 0;
        while (cycles < 1000) begin
            @(posedge clk); #1;
            cycles++;
            if (coreRst !== 1'b1 || inst !== 32'h0) bad++;
            if (ldReady === 1'b1) break;
        end
    endtask

    task automatic checkReads(input int phase);
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                instAdr = vecs[i].adr;
                #1;
                checkOutput(vecs[i].name, inst, vecs[i].exp);
            end
        end
        instAdr = 32'h0;
    endtask

    initial begin
        int cycles;
        int bad;
        logic [7:0] progA [8];
        logic [7:0] progB [5];

        vecs.push_back('{1, 32'h0000_0000, 32'h0005_0820, "A_inst_at_0"});
        vecs.push_back('{1, 32'h0000_0004, 32'h0000_0000, "A_inst_at_4"});
        vecs.push_back('{1, 32'h0000_0003, 32'h0005_0820, "A_low_bits_ignored"});
        vecs.push_back('{2, 32'h0000_0000, 32'h0302_0100, "C_word0_intact"});
        vecs.push_back('{2, 32'h0000_0008, 32'h0B0A_0908, "C_word2"});
        vecs.push_back('{2, 32'h0000_03FC, 32'hFFFE_FDFC, "C_last_word"});
        vecs.push_back('{2, 32'h0000_0400, 32'h0000_0000, "C_past_window"});
        vecs.push_back('{3, 32'h0000_0000, 32'h4433_2211, "B_inst_at_0"});
        vecs.push_back('{3, 32'h0000_0004, 32'h0000_00AA, "B_padded_word"});
        vecs.push_back('{3, 32'h0000_0008, 32'h0000_0000, "B_cleared_word2"});
        vecs.push_back('{3, 32'h0000_03FC, 32'h0000_0000, "B_cleared_last"});
        vecs.push_back('{3, 32'h0000_0401, 32'h0000_0000, "B_out_of_range"});
        vecs.push_back('{4, 32'h0000_0000, 32'h0000_0000, "D_word0_zero"});
        vecs.push_back('{4, 32'h0000_0004, 32'h0000_0000, "D_word1_zero"});
        progA = '{8'h20, 8'h08, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        progB = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};

        doReset("init", 1'b1, cycles, bad);
        checkOutput("clear_cycles", 32'(cycles), 32'd256);
        checkOutput("clear_core_rst_inst_bad", 32'(bad), 32'd0);

`ifndef LOADER_CHECKSUM_EN
        // Back-to-back 8-byte program.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(progA[i], (i == 7), 0);
            if (i == 3) begin
                instAdr = 32'h0;
                #1;
                checkOutput("A_inst_during_load", inst, 32'h0);
                checkOutput("A_loaded_during_load", {31'h0, loaded}, 32'h0);
            end
        end
        checkOutput("A_word_count", 32'(wordCount), 32'd2);
        checkOutput("A_loaded", {31'h0, loaded}, 32'h1);
        checkOutput("A_core_rst", {31'h0, coreRst}, 32'h0);
        checkOutput("A_ld_ready", {31'h0, ldReady}, 32'h0);
        checkReads(1);

        // 1028 bytes: the 257th word overflows and is dropped.
        doReset("C", 1'b0, cycles, bad);
        for (int i = 0; i < 1028; i++) begin
            applyStimulus(8'(i), (i == 1027), 0);
            if (i == 1023) begin
                checkOutput("C_count_at_full", 32'(wordCount), 32'd256);
                checkOutput("C_err_at_full", {31'h0, err}, 32'h0);
            end
        end
        checkOutput("C_err", {31'h0, err}, 32'h1);
        checkOutput("C_word_count", 32'(wordCount), 32'd256);
        checkOutput("C_loaded", {31'h0, loaded}, 32'h1);
        checkReads(2);

        // Gapped 5-byte program with stray ld_last while ld_valid is low.
        doReset("B", 1'b1, cycles, bad);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(progB[i], (i == 4), 2);
        end
        checkOutput("B_word_count", 32'(wordCount), 32'd2);
        checkOutput("B_loaded", {31'h0, loaded}, 32'h1);
        checkReads(3);
        checkOutput("B_err_unchanged", {31'h0, err}, 32'h0);
`endif

        // Reset mid-load after 6 bytes, then reload a zero word.
        doReset("D", 1'b0, cycles, bad);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hFF, 1'b0, 0);
        end
        checkOutput("D_count_before_reset", 32'(wordCount), 32'd1);
        doReset("D_mid", 1'b1, cycles, bad);
        checkOutput("D_clear_cycles", 32'(cycles), 32'd256);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h00, (i == 3), 0);
        end
        checkOutput("D_word_count", 32'(wordCount), 32'd1);
        checkOutput("D_loaded", {31'h0, loaded}, 32'h1);
        checkReads(4);

`ifdef LOADER_CHECKSUM_EN
        // Matching checksum.
        doReset("K", 1'b0, cycles, bad);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i + 1), 1'b0, 0);
        end
        applyStimulus(8'h0A, 1'b1, 0);
        checkOutput("K_loaded", {31'h0, loaded}, 32'h1);
        checkOutput("K_err", {31'h0, err}, 32'h0);
        checkOutput("K_word_count", 32'(wordCount), 32'd1);
        instAdr = 32'h0;
        #1;
        checkOutput("K_inst_at_0", inst, 32'h0403_0201);

        // Mismatching checksum ends in HALT.
        doReset("H", 1'b0, cycles, bad);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'(i + 1), 1'b0, 0);
        end
        applyStimulus(8'h0B, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("H_err", {31'h0, err}, 32'h1);
        checkOutput("H_core_rst", {31'h0, coreRst}, 32'h1);
        checkOutput("H_loaded", {31'h0, loaded}, 32'h0);
        checkOutput("H_ld_ready", {31'h0, ldReady}, 32'h0);
        checkOutput("H_inst", inst, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
